// File: rtl/po_hex_formatter_pkg.sv
// po_hex_formatter_pkg: ASCII constants, FSM encoding and sizing helper for the PO hex formatter.
// Rev 1.0
`default_nettype none

package po_hex_formatter_pkg;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  // 'A' - 10, so nibbles 10..15 land on 'A'..'F'
  localparam logic [7:0] ASCII_HEX_BASE = 8'h37;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  function automatic int calc_nnib(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/po_hex_formatter_hex_ascii_enc.sv
// hex_ascii_enc: combinational 4-bit nibble to uppercase ASCII hex digit.
// Rev 1.0
`default_nettype none

module hex_ascii_enc
  import po_hex_formatter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_ZERO + {4'b0000, nibble};
    else                ascii = ASCII_HEX_BASE + {4'b0000, nibble};
  end

endmodule

`default_nettype wire

// File: rtl/po_hex_formatter.sv
// po_hex_formatter: prints one captured PO word as uppercase hex digits, MSB first, then CR LF, via uart_tx.
// Rev 1.0
`default_nettype none

module po_hex_formatter
  import po_hex_formatter_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] word_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             tx_start_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i
);

  localparam int NNIB  = calc_nnib(WIDTH);
  localparam int WORDW = 4 * NNIB;
  localparam int IDXW  = $clog2(NNIB + 2);

  localparam logic [IDXW-1:0] IDX_CR = IDXW'(NNIB);
  localparam logic [IDXW-1:0] IDX_LF = IDXW'(NNIB + 1);

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WORDW-1:0] word_q;
  logic [3:0]       nibble;
  logic [7:0]       hex_char;
  logic [7:0]       cur_char;

  // Index 0 selects the most significant nibble of the held word.
  always_comb begin
    nibble = '0;
    for (int k = 0; k < NNIB; k++) begin
      if (idx == IDXW'(NNIB - 1 - k)) nibble = word_q[4*k +: 4];
    end
  end

  hex_ascii_enc u_enc (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    if (idx == IDX_CR)      cur_char = ASCII_CR;
    else if (idx == IDX_LF) cur_char = ASCII_LF;
    else                    cur_char = hex_char;
  end

  assign ready_o = (state == ST_IDLE);
  assign busy_o  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      word_q     <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            word_q <= WORDW'(word_i);
            idx    <= '0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready_i) begin
            tx_start_o <= 1'b1;
            tx_data_o  <= cur_char;
            state      <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready_i) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_ready_i) begin
            if (idx == IDX_LF) begin
              state <= ST_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_po_hex_formatter.sv
// tb_po_hex_formatter: scoreboard bench for po_hex_formatter at WIDTH=11 and WIDTH=8.
// Rev 1.0
`default_nettype none

module tb_po_hex_formatter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // ---------------- instance A: WIDTH = 11 ----------------
  logic [10:0] word_a  = '0;
  logic        valid_a = 1'b0;
  logic        ready_a, busy_a, start_a;
  logic [7:0]  data_a;
  logic        txr_a;
  logic        mrdy_a  = 1'b1;
  int          mcnt_a  = 0;
  logic        stall   = 1'b0;

  po_hex_formatter #(.WIDTH(11)) dut_a (
    .clk        (clk),
    .rstn       (rstn),
    .word_i     (word_a),
    .valid_i    (valid_a),
    .ready_o    (ready_a),
    .busy_o     (busy_a),
    .tx_start_o (start_a),
    .tx_data_o  (data_a),
    .tx_ready_i (txr_a)
  );

  // ---------------- instance B: WIDTH = 8 ----------------
  logic [7:0] word_b  = '0;
  logic       valid_b = 1'b0;
  logic       ready_b, busy_b, start_b;
  logic [7:0] data_b;
  logic       txr_b;
  logic       mrdy_b  = 1'b1;
  int         mcnt_b  = 0;

  po_hex_formatter #(.WIDTH(8)) dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .word_i     (word_b),
    .valid_i    (valid_b),
    .ready_o    (ready_b),
    .busy_o     (busy_b),
    .tx_start_o (start_b),
    .tx_data_o  (data_b),
    .tx_ready_i (txr_b)
  );

  // uart_tx models: ready drops one cycle after start, returns 20 cycles later
  assign txr_a = mrdy_a && !stall;
  assign txr_b = mrdy_b;

  always @(posedge clk) begin
    if (start_a) begin
      mrdy_a <= 1'b0;
      mcnt_a <= 20;
    end else if (mcnt_a > 1) begin
      mcnt_a <= mcnt_a - 1;
    end else if (mcnt_a == 1) begin
      mcnt_a <= 0;
      mrdy_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (start_b) begin
      mrdy_b <= 1'b0;
      mcnt_b <= 20;
    end else if (mcnt_b > 1) begin
      mcnt_b <= mcnt_b - 1;
    end else if (mcnt_b == 1) begin
      mcnt_b <= 0;
      mrdy_b <= 1'b1;
    end
  end

  // ---------------- scoreboards and monitors ----------------
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int   starts_a = 0;
  int   starts_b = 0;
  logic prev_start_a = 1'b0;
  logic prev_start_b = 1'b0;
  logic rdy_at_a = 1'b0;
  logic rdy_at_b = 1'b0;

  always @(posedge clk) begin
    rdy_at_a <= txr_a;
    rdy_at_b <= txr_b;
  end

  always @(negedge clk) begin : mon_a
    logic [7:0] e;
    if (start_a) begin
      starts_a++;
      n_asserts++;
      assert (prev_start_a === 1'b0) else begin
        n_fail++; $error("FAIL start_a_twice observed=1 expected=0");
      end
      n_asserts++;
      assert (rdy_at_a === 1'b1) else begin
        n_fail++; $error("FAIL start_a_without_ready observed=%b expected=1", rdy_at_a);
      end
      n_asserts++;
      assert (qa.size() > 0) else begin
        n_fail++; $error("FAIL start_a_unexpected observed=0x%0h expected=none", data_a);
      end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        n_asserts++;
        assert (data_a === e) else begin
          n_fail++; $error("FAIL char_a observed=0x%0h expected=0x%0h", data_a, e);
        end
      end
    end
    prev_start_a <= start_a;
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (start_b) begin
      starts_b++;
      n_asserts++;
      assert (prev_start_b === 1'b0) else begin
        n_fail++; $error("FAIL start_b_twice observed=1 expected=0");
      end
      n_asserts++;
      assert (rdy_at_b === 1'b1) else begin
        n_fail++; $error("FAIL start_b_without_ready observed=%b expected=1", rdy_at_b);
      end
      n_asserts++;
      assert (qb.size() > 0) else begin
        n_fail++; $error("FAIL start_b_unexpected observed=0x%0h expected=none", data_b);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        n_asserts++;
        assert (data_b === e) else begin
          n_fail++; $error("FAIL char_b observed=0x%0h expected=0x%0h", data_b, e);
        end
      end
    end
    prev_start_b <= start_b;
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push5_a(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    qa.push_back(c0); qa.push_back(c1); qa.push_back(c2);
    qa.push_back(8'h0D); qa.push_back(8'h0A);
  endtask

  task automatic push_a(input logic [10:0] w);
    for (int k = 2; k >= 0; k--) qa.push_back(hexc(4'(w >> (4*k))));
    qa.push_back(8'h0D);
    qa.push_back(8'h0A);
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!ready_a && n < 3000) begin @(negedge clk); n++; end
    chk("wait_ready_a", {31'd0, ready_a}, 32'd1);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic accept_a(input logic [10:0] w);
    word_a  = w;
    valid_a = 1'b1;
    wait_ready_a();
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_frame_a(input string tag);
    int n = 0;
    while ((qa.size() != 0 || busy_a) && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_queue_empty"}, qa.size(), 0);
    chk({tag, "_ready"}, {31'd0, ready_a}, 32'd1);
  endtask

  task automatic wait_starts_a(input int target);
    int n = 0;
    while (starts_a < target && n < 3000) begin @(negedge clk); #1; n++; end
    chk("wait_starts_a", {31'd0, (starts_a >= target)}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int base;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
    chk("rst_busy_a",  {31'd0, busy_a},  32'd0);
    chk("rst_start_a", {31'd0, start_a}, 32'd0);
    chk("rst_data_a",  {24'd0, data_a},  32'h00);
    chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
    chk("rst_data_b",  {24'd0, data_b},  32'h00);
    rstn = 1'b1;
    @(negedge clk);

    // single word, with first-start latency
    push5_a(8'h35, 8'h41, 8'h33);
    accept_a(11'h5A3);
    @(posedge clk); #1;
    chk("first_start_latency", {31'd0, start_a}, 32'd1);
    chk("first_start_char", {24'd0, data_a}, 32'h35);
    @(negedge clk);
    wait_frame_a("single_5A3");

    // extremes
    push5_a(8'h37, 8'h46, 8'h46);
    accept_a(11'h7FF);
    wait_frame_a("ext_7FF");
    push5_a(8'h30, 8'h30, 8'h30);
    accept_a(11'h000);
    wait_frame_a("ext_000");

    // WIDTH=8 instance
    qb.push_back(8'h43); qb.push_back(8'h34); qb.push_back(8'h0D); qb.push_back(8'h0A);
    word_b  = 8'hC4;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    chk("b_accept_busy", {31'd0, busy_b}, 32'd1);
    n = 0;
    while ((qb.size() != 0 || busy_b) && n < 5000) begin @(negedge clk); n++; end
    chk("b_queue_empty", qb.size(), 0);
    chk("b_ready", {31'd0, ready_b}, 32'd1);

    // stall: transmitter held not-ready for 100 cycles after accept
    stall = 1'b1;
    push_a(11'h3C6);
    accept_a(11'h3C6);
    for (int i = 0; i < 100; i++) begin
      chk("stall_no_start", {31'd0, start_a}, 32'd0);
      chk("stall_busy", {31'd0, busy_a}, 32'd1);
      @(negedge clk);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_start", {31'd0, start_a}, 32'd1);
    @(negedge clk);
    wait_frame_a("stall_3C6");

    // new word presented mid-frame must wait for ready
    push_a(11'h123);
    base = starts_a;
    accept_a(11'h123);
    wait_starts_a(base + 1);
    chk("midframe_ready_low", {31'd0, ready_a}, 32'd0);
    word_a  = 11'h456;
    valid_a = 1'b1;
    push_a(11'h456);
    @(negedge clk);
    wait_ready_a();
    chk("ignore_queue_second_only", qa.size(), 5);
    @(posedge clk); #1;
    chk("ignore_accept_busy", {31'd0, busy_a}, 32'd1);
    valid_a = 1'b0;
    @(negedge clk);
    wait_frame_a("ignore_busy");

    // back-to-back with valid held high
    push_a(11'h001);
    word_a  = 11'h001;
    valid_a = 1'b1;
    wait_ready_a();
    @(posedge clk); #1;
    word_a = 11'h7FE;
    push_a(11'h7FE);
    @(negedge clk);
    chk("b2b_first_busy", {31'd0, busy_a}, 32'd1);
    wait_ready_a();
    @(posedge clk); #1;
    chk("b2b_second_accepted", {31'd0, busy_a}, 32'd1);
    valid_a = 1'b0;
    @(negedge clk);
    wait_frame_a("b2b");

    // reset in the middle of a frame
    push_a(11'h2B9);
    base = starts_a;
    accept_a(11'h2B9);
    wait_starts_a(base + 2);
    rstn = 1'b0;
    #1;
    chk("midrst_start", {31'd0, start_a}, 32'd0);
    chk("midrst_data",  {24'd0, data_a},  32'h00);
    chk("midrst_ready", {31'd0, ready_a}, 32'd1);
    chk("midrst_busy",  {31'd0, busy_a},  32'd0);
    qa.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base = starts_a;
    repeat (80) @(negedge clk);
    chk("no_start_after_reset", starts_a, base);

    // recovery frame after reset
    push_a(11'h0AB);
    accept_a(11'h0AB);
    wait_frame_a("recover_0AB");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
